// File: rtl/seq_alu_datapath_if.sv
// Command/observation bundle for seq_alu_datapath.
//
// Handshake: a command is taken on the rising clock edge at which cmd_valid
// and cmd_ready are both high. cmd_ready is high only while the datapath is
// idle. All cmd_* fields are captured at that edge, so the master may change
// them afterwards. cmd_valid while cmd_ready is low is ignored, and nothing is
// queued. done pulses for one cycle when a command's final write has landed.
//
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, cmd_ba  command fields
//   done                 one-cycle completion pulse
//   bus_out              internal bus value (observation only)
//   lo_out, hi_out       LO/HI register contents
//   dbg_addr/dbg_data    combinational register-file read port
//   dbg_state            current sequencer state
interface seq_alu_datapath_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [ADDR_W-1:0]     cmd_ra;
  logic [ADDR_W-1:0]     cmd_rb;
  logic [ADDR_W-1:0]     cmd_rd;
  logic [DATA_WIDTH-1:0] cmd_imm;
  logic                  cmd_ba;
  logic                  done;
  logic [DATA_WIDTH-1:0] bus_out;
  logic [DATA_WIDTH-1:0] lo_out;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic [2:0]            dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, cmd_ba, dbg_addr,
    input  cmd_ready, done, bus_out, lo_out, hi_out, dbg_data, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, cmd_ba, dbg_addr,
    output cmd_ready, done, bus_out, lo_out, hi_out, dbg_data, dbg_state
  );
endinterface

// File: rtl/seq_alu_datapath.sv
// Single-bus register-transfer datapath with an internal T-state sequencer.
// One command at a time runs as bus transfers: Ra->Y, Y op Rb->Z, Z->Rd
// (MUL instead writes Z low to LO, then Z high to HI). LDI writes the
// immediate straight to Rd.
//
// Ports:
//   clock  rising-edge clock
//   clear  synchronous active-high reset
//   io     seq_alu_datapath_if.slave (command handshake, results, debug read)
module seq_alu_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input logic               clock,
  input logic               clear,
  seq_alu_datapath_if.slave io
);
  localparam int W      = DATA_WIDTH;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int SH_W   = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [2:0] {IDLE, TA, TB, TW, TH} stateT;

  stateT stateQ, stateD;

  // Latched command
  logic [2:0]        opQ;
  logic [ADDR_W-1:0] raQ, rbQ, rdQ;
  logic [W-1:0]      immQ;
  logic              baQ;

  // Architectural state
  logic [W-1:0]   regFile [NUM_REGS];
  logic [W-1:0]   yQ, loQ, hiQ;
  logic [2*W-1:0] zQ, zNext;
  logic           doneQ;

  // Sequencer control
  logic [W-1:0] busVal, operandA, operandB;
  logic         accept, loadY, loadZ, writeRd, loadLo, loadHi, doneD;

  // Base-address mode masks reads of R0 only; writes to R0 are never masked.
  assign operandA = (baQ && raQ == '0) ? '0 : regFile[raQ];
  assign operandB = (baQ && rbQ == '0) ? '0 : regFile[rbQ];

  always_ff @(posedge clock) begin
    if (clear) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD  = stateQ;
    busVal  = '0;
    accept  = 1'b0;
    loadY   = 1'b0;
    loadZ   = 1'b0;
    writeRd = 1'b0;
    loadLo  = 1'b0;
    loadHi  = 1'b0;
    doneD   = 1'b0;
    case (stateQ)
      IDLE: begin
        if (io.cmd_valid) begin
          accept = 1'b1;
          stateD = TA;
        end
      end
      TA: begin
        if (opQ == OP_LDI) begin
          busVal  = immQ;
          writeRd = 1'b1;
          doneD   = 1'b1;
          stateD  = IDLE;
        end else begin
          busVal = operandA;
          loadY  = 1'b1;
          stateD = TB;
        end
      end
      TB: begin
        busVal = operandB;
        loadZ  = 1'b1;
        stateD = TW;
      end
      TW: begin
        busVal = zQ[W-1:0];
        if (opQ == OP_MUL) begin
          loadLo = 1'b1;
          stateD = TH;
        end else begin
          writeRd = 1'b1;
          doneD   = 1'b1;
          stateD  = IDLE;
        end
      end
      TH: begin
        busVal = zQ[2*W-1:W];
        loadHi = 1'b1;
        doneD  = 1'b1;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // ALU: Y op bus. Shift amount uses only the low log2(W) bits, i.e. mod W.
  // MUL sign-extends both operands to 2W; the low 2W bits of that product
  // equal the signed W x W product.
  logic [SH_W-1:0] shAmt;
  logic [2*W-1:0]  yExt, bExt;

  always_comb begin
    shAmt = busVal[SH_W-1:0];
    yExt  = {{W{yQ[W-1]}}, yQ};
    bExt  = {{W{busVal[W-1]}}, busVal};
    zNext = '0;
    case (opQ)
      OP_ADD: zNext = {{W{1'b0}}, yQ + busVal};
      OP_SUB: zNext = {{W{1'b0}}, yQ - busVal};
      OP_AND: zNext = {{W{1'b0}}, yQ & busVal};
      OP_OR:  zNext = {{W{1'b0}}, yQ | busVal};
      OP_SHL: zNext = {{W{1'b0}}, yQ << shAmt};
      OP_SHR: zNext = {{W{1'b0}}, yQ >> shAmt};
      OP_MUL: zNext = yExt * bExt;
      default: zNext = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
      yQ    <= '0;
      zQ    <= '0;
      loQ   <= '0;
      hiQ   <= '0;
      doneQ <= 1'b0;
      opQ   <= '0;
      raQ   <= '0;
      rbQ   <= '0;
      rdQ   <= '0;
      immQ  <= '0;
      baQ   <= 1'b0;
    end else begin
      doneQ <= doneD;
      if (accept) begin
        opQ  <= io.cmd_op;
        raQ  <= io.cmd_ra;
        rbQ  <= io.cmd_rb;
        rdQ  <= io.cmd_rd;
        immQ <= io.cmd_imm;
        baQ  <= io.cmd_ba;
      end
      if (loadY)   yQ <= busVal;
      if (loadZ)   zQ <= zNext;
      if (writeRd) regFile[rdQ] <= busVal;
      if (loadLo)  loQ <= zQ[W-1:0];
      if (loadHi)  hiQ <= busVal;
    end
  end

  assign io.cmd_ready = (stateQ == IDLE);
  assign io.done      = doneQ;
  assign io.bus_out   = busVal;
  assign io.lo_out    = loQ;
  assign io.hi_out    = hiQ;
  assign io.dbg_data  = regFile[io.dbg_addr];
  assign io.dbg_state = stateQ;
endmodule

// File: tb/tb_seq_alu_datapath.sv
// Testbench for seq_alu_datapath: a 32-bit/16-register instance exercised by
// a vector table, hand-written multi-cycle sequences and random commands
// checked against a spec-level model, plus an 8-bit/4-register instance.
module tb_seq_alu_datapath;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic clear32, clear8;
  always #5 clock = ~clock;

  seq_alu_datapath_if #(.DATA_WIDTH(32), .NUM_REGS(16)) if32();
  seq_alu_datapath_if #(.DATA_WIDTH(8),  .NUM_REGS(4))  if8();

  seq_alu_datapath #(.DATA_WIDTH(32), .NUM_REGS(16)) dut32 (
    .clock(clock), .clear(clear32), .io(if32)
  );
  seq_alu_datapath #(.DATA_WIDTH(8), .NUM_REGS(4)) dut8 (
    .clock(clock), .clear(clear8), .io(if8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bus_trace[$];
  logic [31:0] m_regs[16];
  logic [31:0] m_lo, m_hi;

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic        ba;
    logic [31:0] exp_val;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_lo = '0;
    m_hi = '0;
    exp_q.delete();
  endtask

  // Spec-level behaviour: read both operands (R0 reads 0 in ba mode), then
  // apply the operation with plain arithmetic.
  task automatic model_exec(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rd, input logic [31:0] imm, input logic ba);
    logic [31:0] a, b;
    longint p;
    a = (ba && ra == 0) ? 32'd0 : m_regs[ra];
    b = (ba && rb == 0) ? 32'd0 : m_regs[rb];
    case (op)
      OP_ADD: m_regs[rd] = a + b;
      OP_SUB: m_regs[rd] = a - b;
      OP_AND: m_regs[rd] = a & b;
      OP_OR:  m_regs[rd] = a | b;
      OP_SHL: m_regs[rd] = a << (b % 32);
      OP_SHR: m_regs[rd] = a >> (b % 32);
      OP_MUL: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_lo = p[31:0];
        m_hi = p[63:32];
      end
      default: m_regs[rd] = imm;
    endcase
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    if (op == OP_LDI) return 1;
    if (op == OP_MUL) return 4;
    return 3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic read_reg(input logic [3:0] idx, output logic [31:0] v);
    if32.dbg_addr = idx;
    @(negedge clock);
    v = if32.dbg_data;
  endtask

  // Issues one command on the 32-bit instance, records bus_out for every
  // cycle from acceptance up to the done cycle, returns cycles to done.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rd, input logic [31:0] imm, input logic ba,
                         output int lat);
    int guard;
    bit seen;
    guard = 0;
    lat = 0;
    while (if32.cmd_ready !== 1'b1 && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 20) begin
      fail_now("ready_wait");
      return;
    end
    if32.cmd_op = op; if32.cmd_ra = ra; if32.cmd_rb = rb; if32.cmd_rd = rd;
    if32.cmd_imm = imm; if32.cmd_ba = ba; if32.cmd_valid = 1'b1;
    @(posedge clock); #1;
    if32.cmd_valid = 1'b0;
    // Scramble fields: the DUT must be using its latched copy.
    if32.cmd_op = 3'($urandom_range(0, 7)); if32.cmd_ra = 4'($urandom_range(0, 15));
    if32.cmd_rb = 4'($urandom_range(0, 15)); if32.cmd_rd = 4'($urandom_range(0, 15));
    if32.cmd_imm = $urandom(); if32.cmd_ba = 1'($urandom_range(0, 1));
    bus_trace.delete();
    seen = 0;
    while (!seen && lat < 8) begin
      bus_trace.push_back(if32.bus_out);
      @(posedge clock); #1;
      lat++;
      if (if32.done === 1'b1) seen = 1;
    end
    if (!seen) begin
      fail_now("done_wait");
      lat = 0;
    end
  endtask

  task automatic do_cmd(input string name, input logic [2:0] op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rd, input logic [31:0] imm,
                        input logic ba);
    int lat;
    logic [31:0] e;
    model_exec(op, ra, rb, rd, imm, ba);
    if (op == OP_MUL) begin
      exp_q.push_back(m_lo);
      exp_q.push_back(m_hi);
    end else begin
      exp_q.push_back(m_regs[rd]);
    end
    run_cmd(op, ra, rb, rd, imm, ba, lat);
    if (lat == 0) begin
      exp_q.delete();
      return;
    end
    check({name, "_lat"}, lat, exp_lat(op));
    if (op == OP_MUL) begin
      e = exp_q.pop_front();
      check({name, "_lo"}, if32.lo_out, e);
      e = exp_q.pop_front();
      check({name, "_hi"}, if32.hi_out, e);
      if (bus_trace.size() >= 4) check({name, "_hibus"}, bus_trace[3], e);
    end else begin
      e = exp_q.pop_front();
      check({name, "_wbus"}, bus_trace[bus_trace.size()-1], e);
    end
  endtask

  task automatic run8(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                      input logic [1:0] rd, input logic [7:0] imm, output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    if8.cmd_op = op; if8.cmd_ra = ra; if8.cmd_rb = rb; if8.cmd_rd = rd;
    if8.cmd_imm = imm; if8.cmd_ba = 1'b0; if8.cmd_valid = 1'b1;
    @(posedge clock); #1;
    if8.cmd_valid = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge clock); #1;
      lat++;
      if (if8.done === 1'b1) seen = 1;
    end
    if (!seen) begin
      fail_now("done_wait8");
      lat = 0;
    end
  endtask

  task automatic read8(input logic [1:0] idx, output logic [7:0] v);
    if8.dbg_addr = idx;
    @(negedge clock);
    v = if8.dbg_data;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] v;
    logic [7:0]  v8;
    int done_cnt, lat;
    logic [2:0]  op;

    vecs[0]  = '{OP_LDI, 4'd0, 4'd0, 4'd1,  32'd3,          1'b0, 32'd3,          32'd0};
    vecs[1]  = '{OP_LDI, 4'd0, 4'd0, 4'd2,  32'd93,         1'b0, 32'd93,         32'd0};
    vecs[2]  = '{OP_SUB, 4'd1, 4'd2, 4'd4,  32'd0,          1'b0, 32'hFFFFFFA6,   32'd0};
    vecs[3]  = '{OP_LDI, 4'd0, 4'd0, 4'd5,  32'd33,         1'b0, 32'd33,         32'd0};
    vecs[4]  = '{OP_SHL, 4'd2, 4'd5, 4'd6,  32'd0,          1'b0, 32'd186,        32'd0};
    vecs[5]  = '{OP_SHR, 4'd2, 4'd5, 4'd7,  32'd0,          1'b0, 32'd46,         32'd0};
    vecs[6]  = '{OP_AND, 4'd2, 4'd1, 4'd8,  32'd0,          1'b0, 32'd1,          32'd0};
    vecs[7]  = '{OP_OR,  4'd2, 4'd1, 4'd9,  32'd0,          1'b0, 32'd95,         32'd0};
    vecs[8]  = '{OP_LDI, 4'd0, 4'd0, 4'd0,  32'd7,          1'b0, 32'd7,          32'd0};
    vecs[9]  = '{OP_ADD, 4'd0, 4'd1, 4'd10, 32'd0,          1'b1, 32'd3,          32'd0};
    vecs[10] = '{OP_ADD, 4'd0, 4'd1, 4'd11, 32'd0,          1'b0, 32'd10,         32'd0};
    vecs[11] = '{OP_LDI, 4'd0, 4'd0, 4'd0,  32'd5,          1'b1, 32'd5,          32'd0};
    vecs[12] = '{OP_ADD, 4'd3, 4'd0, 4'd12, 32'd0,          1'b1, 32'd9,          32'd0};
    vecs[13] = '{OP_ADD, 4'd3, 4'd0, 4'd13, 32'd0,          1'b0, 32'd14,         32'd0};
    vecs[14] = '{OP_LDI, 4'd0, 4'd0, 4'd14, 32'hFFFFFFFD,   1'b0, 32'hFFFFFFFD,   32'd0};
    vecs[15] = '{OP_MUL, 4'd14, 4'd2, 4'd15, 32'd0,         1'b0, 32'hFFFFFEE9,   32'hFFFFFFFF};
    vecs[16] = '{OP_LDI, 4'd0, 4'd0, 4'd11, 32'hFFFFFFFF,   1'b0, 32'hFFFFFFFF,   32'd0};
    vecs[17] = '{OP_ADD, 4'd11, 4'd1, 4'd11, 32'd0,         1'b0, 32'd2,          32'd0};
    vecs[18] = '{OP_SHR, 4'd14, 4'd1, 4'd9, 32'd0,          1'b0, 32'h1FFFFFFF,   32'd0};

    if32.cmd_valid = 1'b0; if32.cmd_op = '0; if32.cmd_ra = '0; if32.cmd_rb = '0;
    if32.cmd_rd = '0; if32.cmd_imm = '0; if32.cmd_ba = 1'b0; if32.dbg_addr = '0;
    if8.cmd_valid = 1'b0; if8.cmd_op = '0; if8.cmd_ra = '0; if8.cmd_rb = '0;
    if8.cmd_rd = '0; if8.cmd_imm = '0; if8.cmd_ba = 1'b0; if8.dbg_addr = '0;
    clear32 = 1'b1;
    clear8  = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    clear32 = 1'b0;
    clear8  = 1'b0;

    // Reset state
    check("rst_ready", if32.cmd_ready, 1);
    check("rst_done", if32.done, 0);
    check("rst_bus", if32.bus_out, 0);
    check("rst_lo", if32.lo_out, 0);
    check("rst_hi", if32.hi_out, 0);

    // LDI after reset: one-edge latency, one-cycle done, ready in done cycle
    do_cmd("ldi_r3", OP_LDI, 4'd0, 4'd0, 4'd3, 32'd9, 1'b0);
    check("ldi_ready_in_done", if32.cmd_ready, 1);
    @(posedge clock); #1;
    check("ldi_done_width", if32.done, 0);
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check($sformatf("ldi_reg%0d", i), v, (i == 3) ? 32'd9 : 32'd0);
    end

    // Vector table
    for (int i = 0; i < 19; i++) begin
      do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd,
             vecs[i].imm, vecs[i].ba);
      if (vecs[i].op == OP_MUL) begin
        check($sformatf("vec%0d_lo", i), if32.lo_out, vecs[i].exp_val);
        check($sformatf("vec%0d_hi", i), if32.hi_out, vecs[i].exp_hi);
      end else begin
        read_reg(vecs[i].rd, v);
        check($sformatf("vec%0d_rd", i), v, vecs[i].exp_val);
      end
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check($sformatf("tbl_reg%0d", i), v, m_regs[i]);
    end

    // ADD with aliasing: bus shows Ra, Rb, result
    do_cmd("add_alias", OP_ADD, 4'd2, 4'd1, 4'd2, 32'd0, 1'b0);
    if (bus_trace.size() >= 3) begin
      check("alias_bus0", bus_trace[0], 32'd93);
      check("alias_bus1", bus_trace[1], 32'd3);
      check("alias_bus2", bus_trace[2], 32'd96);
    end else begin
      fail_now("alias_trace");
    end
    read_reg(4'd2, v);
    check("alias_r2", v, 32'd96);

    // cmd_valid held through a whole command: exactly one execution
    model_exec(OP_ADD, 4'd1, 4'd1, 4'd1, 32'd0, 1'b0);
    done_cnt = 0;
    if32.cmd_op = OP_ADD; if32.cmd_ra = 4'd1; if32.cmd_rb = 4'd1; if32.cmd_rd = 4'd1;
    if32.cmd_imm = '0; if32.cmd_ba = 1'b0; if32.cmd_valid = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      if (if32.done === 1'b1) done_cnt++;
    end
    if32.cmd_valid = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (if32.done === 1'b1) done_cnt++;
    end
    check("busy_done_cnt", done_cnt, 1);
    read_reg(4'd1, v);
    check("busy_r1", v, m_regs[1]);

    // Reset during TB aborts the command
    if32.cmd_op = OP_ADD; if32.cmd_ra = 4'd2; if32.cmd_rb = 4'd1; if32.cmd_rd = 4'd5;
    if32.cmd_ba = 1'b0; if32.cmd_valid = 1'b1;
    @(posedge clock); #1;
    if32.cmd_valid = 1'b0;
    @(posedge clock); #1;
    clear32 = 1'b1;
    @(posedge clock); #1;
    clear32 = 1'b0;
    model_reset();
    done_cnt = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (if32.done === 1'b1) done_cnt++;
    end
    check("abort_done_cnt", done_cnt, 0);
    check("abort_ready", if32.cmd_ready, 1);
    check("abort_bus", if32.bus_out, 0);
    check("abort_lo", if32.lo_out, 0);
    check("abort_hi", if32.hi_out, 0);
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check($sformatf("abort_reg%0d", i), v, 32'd0);
    end

    // Random back-to-back commands against the model
    @(posedge clock); #1;
    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 9) < 3) ? OP_LDI : 3'($urandom_range(0, 6));
      do_cmd($sformatf("rnd%0d", n), op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
             1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check($sformatf("rnd_reg%0d", i), v, m_regs[i]);
    end

    // 8-bit, 4-register instance
    @(posedge clock); #1;
    run8(OP_LDI, 2'd0, 2'd0, 2'd1, 8'd200, lat);
    run8(OP_LDI, 2'd0, 2'd0, 2'd2, 8'd100, lat);
    run8(OP_ADD, 2'd1, 2'd2, 2'd3, 8'd0, lat);
    check("w8_add_lat", lat, 3);
    read8(2'd3, v8);
    check("w8_add", v8, 8'd44);
    run8(OP_SUB, 2'd2, 2'd1, 2'd3, 8'd0, lat);
    read8(2'd3, v8);
    check("w8_sub", v8, 8'h9C);
    run8(OP_MUL, 2'd1, 2'd2, 2'd0, 8'd0, lat);
    check("w8_mul_lat", lat, 4);
    check("w8_mul_lo", if8.lo_out, 8'h20);
    check("w8_mul_hi", if8.hi_out, 8'hEA);
    read8(2'd0, v8);
    check("w8_mul_r0", v8, 8'd0);
    run8(OP_LDI, 2'd0, 2'd0, 2'd0, 8'd9, lat);
    run8(OP_SHL, 2'd2, 2'd0, 2'd3, 8'd0, lat);
    read8(2'd3, v8);
    check("w8_shl_mod", v8, 8'd200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
